// File: rtl/a1csa_pipe.sv
// Two-stage pipelined add-one carry-select adder/subtractor with valid/ready flow control.
// Define A1CSA_PIPE_OVF_EN to add the signed-overflow output ovf.
module a1csa_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef A1CSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NB = WIDTH / BLK;

  if (((WIDTH % BLK) != 0) || (WIDTH < 2 * BLK)) begin : g_param_check
    $error("a1csa_pipe: WIDTH must be a multiple of BLK and at least 2*BLK");
  end

  logic adv1, adv2;
  logic v1_q, v2_q;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1: independent per-block sums; only block 0 sees the real carry-in.
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [BLK:0]     blk_sum;
  logic [WIDTH-1:0] s0_d, s0_q;
  logic [NB-1:0]    gen_d, gen_q, prop_d, prop_q;

  assign bx = sub ? ~b : b;
  assign c0 = sub | cin;

  always_comb begin
    s0_d    = '0;
    gen_d   = '0;
    prop_d  = '0;
    blk_sum = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      blk_sum = {1'b0, a[k*BLK +: BLK]} + {1'b0, bx[k*BLK +: BLK]}
              + {{BLK{1'b0}}, (k == 0) ? c0 : 1'b0};
      s0_d[k*BLK +: BLK] = blk_sum[BLK-1:0];
      gen_d[k]           = blk_sum[BLK];
      prop_d[k]          = &blk_sum[BLK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s0_q   <= '0;
      gen_q  <= '0;
      prop_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s0_q   <= s0_d;
        gen_q  <= gen_d;
        prop_q <= prop_d;
      end
    end
  end

  // Stage 2: resolve block carries, add one to every block whose select is set.
  logic [WIDTH-1:0] sum_d;
  logic             sel;
  logic             cout_d;

  always_comb begin
    sum_d  = '0;
    sel    = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      sum_d[k*BLK +: BLK] = sel ? (s0_q[k*BLK +: BLK] + BLK'(1)) : s0_q[k*BLK +: BLK];
      sel                 = gen_q[k] | (prop_q[k] & sel);
    end
    cout_d = sel;
  end

  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s_q    <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign s         = s_q;
  assign cout      = cout_q;

`ifdef A1CSA_PIPE_OVF_EN
  logic a_msb_q, bx_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
    end else if (adv1 && in_valid) begin
      a_msb_q  <= a[WIDTH-1];
      bx_msb_q <= bx[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv2 && v1_q) begin
      ovf_q <= (a_msb_q == bx_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
